// File: rtl/fact_cu.sv
// Control unit for the iterative 4-bit factorial accelerator.
// Moore FSM: every strobe is decoded from the state register alone.
module fact_cu (
  input  logic clk,
  input  logic rst,
  input  logic go,
  input  logic gt_in,
  input  logic gt_fact,
  output logic load_cnt,
  output logic en,
  output logic sel_1,
  output logic load_reg,
  output logic sel_2,
  output logic busy,
  output logic done,
  output logic err
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_INIT = 3'd1;
  localparam logic [2:0] S_TEST = 3'd2;
  localparam logic [2:0] S_MUL  = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  logic [2:0] state, state_nxt;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // gt_fact is only meaningful in TEST, one cycle after the counter moved
  always_comb begin
    state_nxt = S_IDLE;
    case (state)
      S_IDLE:  state_nxt = go ? (gt_in ? S_ERR : S_INIT) : S_IDLE;
      S_INIT:  state_nxt = S_TEST;
      S_TEST:  state_nxt = gt_fact ? S_MUL : S_DONE;
      S_MUL:   state_nxt = S_TEST;
      S_DONE:  state_nxt = go ? S_DONE : S_IDLE;
      S_ERR:   state_nxt = go ? S_ERR : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    load_cnt = 1'b0;
    en       = 1'b0;
    sel_1    = 1'b0;
    load_reg = 1'b0;
    sel_2    = 1'b0;
    busy     = 1'b0;
    done     = 1'b0;
    err      = 1'b0;
    case (state)
      S_INIT: begin
        load_cnt = 1'b1;
        load_reg = 1'b1;
        busy     = 1'b1;
      end
      S_TEST: busy = 1'b1;
      S_MUL: begin
        en       = 1'b1;
        load_reg = 1'b1;
        sel_1    = 1'b1;
        busy     = 1'b1;
      end
      S_DONE: begin
        sel_2 = 1'b1;
        done  = 1'b1;
      end
      S_ERR:   err = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fact_cu.sv
// Bench for fact_cu: behavioural datapath attached, results checked against
// factorial arithmetic and closed-form latency.
module tb_fact_cu;

  logic clk = 1'b0;
  logic rst, go;
  logic load_cnt, en, sel_1, load_reg, sel_2, busy, done, err;
  logic [3:0] n, cnt, prod;
  logic gt_in, gt_fact;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  fact_cu dut (
    .clk(clk), .rst(rst), .go(go), .gt_in(gt_in), .gt_fact(gt_fact),
    .load_cnt(load_cnt), .en(en), .sel_1(sel_1), .load_reg(load_reg),
    .sel_2(sel_2), .busy(busy), .done(done), .err(err)
  );

  // datapath model driven by the control strobes
  assign gt_in   = (n > 4'd12);
  assign gt_fact = (cnt > 4'd1);
  always @(posedge clk) begin
    if (load_cnt)  cnt <= n;
    else if (en)   cnt <= cnt - 4'd1;
    if (load_reg)  prod <= sel_1 ? 4'(prod * cnt) : 4'd1;
  end

  wire [7:0] outs = {load_cnt, en, sel_1, load_reg, sel_2, busy, done, err};

  task automatic chk(input string tag, input int obs, input int exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      chk("excl_ld_en", int'(load_cnt & en), 0);
      chk("excl_bde", int'($countones({busy, done, err}) <= 1), 1);
    end
  end

  function automatic int ref_lat(input int v);
    return (v <= 1) ? 3 : 3 + 2 * (v - 1);
  endfunction

  function automatic int ref_fact(input int v);
    int p = 1;
    for (int i = 2; i <= v; i++) p = p * i;
    return p % 16;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // one request from IDLE; extra = cycles go is held high after completion
  task automatic run_req(input int v, input bit glitch, input int extra);
    int k, n_init, n_mul, any_ld;
    bit fin;
    chk("idle_before", int'(outs), 0);
    n = 4'(v);
    go = 1'b1;
    k = 0; n_init = 0; n_mul = 0; any_ld = 0; fin = 1'b0;
    while (!fin && k < 40) begin
      tick();
      k++;
      go = !(glitch && k == 2);
      n_init += int'(load_cnt);
      n_mul  += int'(en);
      any_ld |= int'(load_cnt | en | load_reg);
      fin = done | err;
    end
    if (!fin) begin
      chk("timeout", k, -1);
      return;
    end
    if (v > 12) begin
      chk("err_lat", k, 1);
      chk("err_flag", int'(err), 1);
      chk("err_no_load", any_ld, 0);
    end else begin
      chk("done_lat", k, ref_lat(v));
      chk("init_cnt", n_init, 1);
      chk("mul_cnt", n_mul, (v <= 1) ? 0 : v - 1);
      chk("sel_2", int'(sel_2), 1);
      chk("product", int'(prod), ref_fact(v));
    end
    for (int i = 0; i < extra; i++) begin
      tick();
      chk("hold", int'(outs), (v > 12) ? 8'h01 : 8'h0A);
      if (v > 12) chk("err_no_load_hold", int'(load_cnt | en | load_reg), 0);
    end
    go = 1'b0;
    tick();
    chk("release", int'(outs), 0);
  endtask

  initial begin
    int w;
    rst = 1'b1; go = 1'b0; n = 4'd0;
    tick();
    rst = 1'b0;
    chk("reset", int'(outs), 0);

    // reset during MUL aborts cleanly
    n = 4'd5; go = 1'b1;
    w = 0;
    while (!en && w < 20) begin tick(); w++; end
    chk("saw_mul", int'(en), 1);
    tick(); tick();  // TEST then second MUL
    chk("mid_mul", int'(en), 1);
    rst = 1'b1; go = 1'b0;
    tick();
    rst = 1'b0;
    chk("abort", int'(outs), 0);
    tick();
    chk("abort_stay", int'(outs), 0);
    run_req(3, 1'b0, 0);

    // directed cases
    run_req(4, 1'b0, 2);
    run_req(0, 1'b0, 0);
    run_req(1, 1'b0, 1);
    run_req(13, 1'b0, 3);
    run_req(12, 1'b0, 0);
    run_req(3, 1'b0, 4);
    run_req(2, 1'b0, 0);
    run_req(4, 1'b1, 0);
    run_req(15, 1'b1, 0);

    // randomized requests
    for (int r = 0; r < 60; r++)
      run_req(int'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
              int'($urandom_range(0, 3)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fact_cu.md
Name: fact_cu

Overview:
- Control unit for the iterative 4-bit factorial accelerator.
- Accepts a go request and sequences the factorial datapath through its control strobes: counter load/decrement, product register load, multiplexer selects.
- Consumes the datapath status flags (input-range error, counter > 1) and reports busy/done/err to the SoC-side requester.
- Sits between the SoC register wrapper (initiator) and the factorial datapath (responder).

Parameters:
- None. Datapath width is fixed at 4 bits. The range limit (n > 12) is evaluated in the datapath and arrives as gt_in.

Ports:
- clk  input  1  system clock, rising-edge
- rst  input  1  synchronous, active-high reset
- go  input  1  start request; level-sensitive, sampled only in IDLE, DONE and ERR
- gt_in  input  1  datapath flag: operand n > 12 (invalid)
- gt_fact  input  1  datapath flag: current counter value > 1
- load_cnt  output  1  load down-counter with n
- en  output  1  decrement down-counter
- sel_1  output  1  product-register input select: 0 = constant 1, 1 = product × counter
- load_reg  output  1  product-register write enable
- sel_2  output  1  result output select: 1 = drive product, 0 = drive zero
- busy  output  1  computation in progress
- done  output  1  result valid
- err  output  1  request rejected, operand out of range

Behaviour:
- Reset: a single clk edge with rst=1 forces IDLE. All outputs are 0 in IDLE.
- rst asserted mid-operation aborts the computation; no done or err is produced for it.
- Outputs are Moore-decoded from the state register only; no output depends combinationally on go or on the flags.
- States and outputs (unlisted outputs are 0):
  - IDLE: all 0.
  - INIT: load_cnt=1, load_reg=1, sel_1=0, busy=1.
  - TEST: busy=1.
  - MUL: en=1, load_reg=1, sel_1=1, busy=1.
  - DONE: sel_2=1, done=1.
  - ERR: err=1.
- Transitions, evaluated at each clk edge:
  - IDLE: go & gt_in -> ERR; go & !gt_in -> INIT; else stay in IDLE.
  - INIT -> TEST, unconditional.
  - TEST: gt_fact -> MUL; else -> DONE.
  - MUL -> TEST, unconditional.
  - DONE: !go -> IDLE; else stay.
  - ERR: !go -> IDLE; else stay.
- gt_fact is sampled only in TEST, one cycle after the counter update, so it reflects the post-load or post-decrement value.
- Latency, counted from the edge that samples go in IDLE to the first cycle with done=1: 3 cycles for n ≤ 1, 3 + 2·(n−1) cycles for 2 ≤ n ≤ 12. Examples: n=0 -> 3, n=1 -> 3, n=4 -> 9, n=12 -> 25.
- Error path: err=1 one cycle after the sampling edge. load_cnt, en and load_reg are never asserted on the error path.
- Handshake:
  - The requester holds n stable from the go-sampling edge through the INIT cycle.
  - done and err are held until go is seen low.
  - go held high continuously never auto-restarts; a new request requires go low for at least one cycle, then high again.
  - go toggling while busy=1 is ignored.
- Mutual exclusion: exactly one of busy/done/err is high in non-IDLE states. load_cnt and en are never high together.
- Illegal or unused state encodings recover to IDLE on the next edge.

Test Plan:
- Reset mid-MUL: start n=5, assert rst for 1 cycle during a MUL cycle -> next cycle all outputs 0 and state is IDLE. A later go with n=3 completes normally.
- n=4, go held high, datapath model attached -> done=1 exactly 9 cycles after the sampling edge. Bench records MUL count = 3 and INIT count = 1. sel_2=1 with done, and the model's product reads 24 mod 16 = 8.
- n=0 and n=1 -> one INIT, one TEST, no MUL. done=1 at cycle 3 with product = 1.
- n=13, go=1 -> err=1 at cycle 1. load_cnt, en and load_reg stay 0 throughout. err stays 1 while go=1 and drops the cycle after go=0.
- Back-to-back: n=3 completes (done at cycle 7). go kept high for 4 extra cycles -> stays in DONE with no restart. go low 1 cycle then high with n=2 -> second done at cycle 5 after the new sampling edge.
- Glitch and exclusion checks: pulse go while busy -> no effect on sequence or latency. Assertion monitors across all runs flag any overlap of load_cnt with en, or of busy/done/err.
